// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ==== mem_bus_arbiter: round-robin two-master sequencer for one memory port ====
// Revision 1.0 -- one access at a time, bounded by a timeout, all outputs registered.
module mem_bus_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rstIn,
  input  logic          m0_rd,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_mfc,
  input  logic          m1_rd,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_mfc,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic [1:0]    gnt,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state;
  logic          prio;
  logic          cur;
  logic          cur_wr;
  logic [7:0]    tmo_cnt;

  logic          req0;
  logic          req1;
  logic          pick;
  logic          cur_req;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] done_data;
  logic          acc_done;

  assign req0 = m0_rd | m0_wr;
  assign req1 = m1_rd | m1_wr;

  // Contention goes to the prio master; a lone requester always wins.
  assign pick      = (req0 && req1) ? prio : req1;
  assign cur_req   = cur ? req1 : req0;
  assign sel_wr    = pick ? m1_wr : m0_wr;
  assign sel_addr  = pick ? m1_addr : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign done_data = mem_rdy ? mem_rdata : {DW{1'b1}};
  assign acc_done  = mem_rdy || (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      cur       <= 1'b0;
      cur_wr    <= 1'b0;
      tmo_cnt   <= 8'd0;
      gnt       <= 2'b00;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_mfc    <= 1'b0;
      m1_mfc    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            cur       <= pick;
            cur_wr    <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wr    <= sel_wr;
            mem_rd    <= ~sel_wr;
            gnt       <= pick ? 2'b10 : 2'b01;
            tmo_cnt   <= 8'd0;
            state     <= S_ACC;
          end
        end
        S_ACC: begin
          if (acc_done) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!cur_wr) begin
              if (cur) m1_rdata <= done_data;
              else     m0_rdata <= done_data;
            end
            if (!mem_rdy) bus_err <= 1'b1;
            // A master that withdrew during the access never sees mfc.
            if (cur_req) begin
              if (cur) m1_mfc <= 1'b1;
              else     m0_mfc <= 1'b1;
              state <= S_ACK;
            end else begin
              gnt   <= 2'b00;
              prio  <= ~cur;
              state <= S_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_ACK: begin
          if (!cur_req) begin
            m0_mfc <= 1'b0;
            m1_mfc <= 1'b0;
            gnt    <= 2'b00;
            prio   <= ~cur;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ==== tb_mem_bus_arbiter: scoreboard bench with a transaction-level arbiter/memory model ====
// Revision 1.0
module tb_mem_bus_arbiter;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_mfc, m1_mfc;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic [1:0]  gnt;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(16), .DW(16), .TMO(TMO)) dut (
    .clk(clk), .rstIn(rstIn),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_mfc(m0_mfc),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_mfc(m1_mfc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .gnt(gnt), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t        exp_req0[$];
  req_t        exp_req1[$];
  logic [15:0] exp_resp0[$];
  logic [15:0] exp_resp1[$];
  int          grant_log[$];
  logic [15:0] mem_model [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int force_w = -1;
  logic [1:0] last_req = 2'b00;

  // Requests as the DUT sampled them at the most recent rising edge.
  always @(posedge clk) last_req <= {m1_rd | m1_wr, m0_rd | m0_wr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memval(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'h5A5A;
  endfunction

  // Scoreboard/monitor state
  logic        strobe, prev_strobe;
  logic [1:0]  prev_gnt, prev_mfc;
  bit          active;
  int          cur_m, w, dur, win, prio_model;
  int          timeouts_exp, bus_err_cycles;
  logic        cur_wr, tmo_hit, mfc_exp, mf;
  logic [15:0] cur_addr, cur_wdata, rdval, expv, prd0, prd1;
  req_t        r_mon;

  initial begin : monitor
    mem_rdy = 1'b0; mem_rdata = 16'h0;
    prev_strobe = 1'b0; prev_gnt = 2'b00; prev_mfc = 2'b00; active = 0;
    prio_model = 0; prd0 = 16'h0; prd1 = 16'h0; timeouts_exp = 0; bus_err_cycles = 0;
    cur_m = 0; w = 0; dur = 0; rdval = 16'h0; cur_wr = 1'b0; cur_addr = 16'h0; cur_wdata = 16'h0;
    forever begin
      @(negedge clk);
      if (rstIn) begin
        active = 0; prio_model = 0; prd0 = 16'h0; prd1 = 16'h0;
        prev_strobe = 1'b0; prev_gnt = 2'b00; prev_mfc = 2'b00;
        mem_rdy = 1'b0;
        exp_resp0.delete(); exp_resp1.delete();
      end else begin
        strobe = mem_rd | mem_wr;
        mem_rdy = 1'b0;
        mem_rdata = 16'($urandom);
        if (bus_err) bus_err_cycles++;
        // New grant: winner is the lone requester or the round-robin favourite.
        if (strobe && !prev_strobe) begin
          chk("dead_cycle_gnt", 32'(prev_gnt), 32'd0);
          case (last_req)
            2'b01:   win = 0;
            2'b10:   win = 1;
            2'b11:   win = prio_model;
            default: win = -1;
          endcase
          if (win < 0) begin
            checks++; errors++;
            $display("FAIL grant_no_request: got request vector %b, required nonzero", last_req);
            win = 0;
          end
          chk("gnt_onehot", 32'(gnt), (win == 1) ? 32'd2 : 32'd1);
          grant_log.push_back(win);
          prio_model = (win == 1) ? 0 : 1;
          if ((win == 1 ? exp_req1.size() : exp_req0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access: got access for m%0d, required none pending", win);
            active = 0;
          end else begin
            r_mon = (win == 1) ? exp_req1.pop_front() : exp_req0.pop_front();
            chk("op_wr", 32'(mem_wr), 32'(r_mon.wr));
            chk("op_rd", 32'(mem_rd), 32'(!r_mon.wr));
            chk("mem_addr", 32'(mem_addr), 32'(r_mon.addr));
            if (r_mon.wr) chk("mem_wdata", 32'(mem_wdata), 32'(r_mon.wdata));
            cur_m = win; cur_wr = r_mon.wr; cur_addr = r_mon.addr; cur_wdata = r_mon.wdata;
            if (force_w >= 0) w = force_w;
            else w = ($urandom_range(0, 5) == 0) ? TMO : int'($urandom_range(0, 4));
            dur = 0;
            active = 1;
          end
        end
        if (strobe && active) begin
          dur++;
          if (dur > 1) chk("addr_stable", 32'(mem_addr), 32'(cur_addr));
          if (w < TMO && dur == w + 1) begin
            rdval = memval(cur_addr);
            mem_rdy = 1'b1;
            mem_rdata = rdval;
          end
        end
        if (!strobe && prev_strobe && active) begin
          tmo_hit = (w >= TMO);
          chk("strobe_cycles", 32'(dur), tmo_hit ? 32'(TMO) : 32'(w + 1));
          chk("bus_err_pulse", 32'(bus_err), 32'(tmo_hit));
          if (tmo_hit) timeouts_exp++;
          if (!cur_wr) begin
            expv = tmo_hit ? 16'hFFFF : rdval;
            if (cur_m == 1) prd1 = expv; else prd0 = expv;
          end else begin
            if (!tmo_hit) mem_model[cur_addr] = cur_wdata;
            expv = (cur_m == 1) ? prd1 : prd0;
          end
          mfc_exp = last_req[cur_m];
          chk("mfc_on_done", 32'((cur_m == 1) ? m1_mfc : m0_mfc), 32'(mfc_exp));
          if (mfc_exp) begin
            if (cur_m == 1) exp_resp1.push_back(expv); else exp_resp0.push_back(expv);
          end
          active = 0;
        end else begin
          chk("bus_err_quiet", 32'(bus_err), 32'd0);
        end
        for (int m = 0; m < 2; m++) begin
          mf = (m == 1) ? m1_mfc : m0_mfc;
          if (mf && !prev_mfc[m]) begin
            if ((m == 1 ? exp_resp1.size() : exp_resp0.size()) == 0) begin
              checks++; errors++;
              $display("FAIL mfc_unexpected: got mfc on m%0d, required 0", m);
            end else if (m == 1) chk("m1_rdata", 32'(m1_rdata), 32'(exp_resp1.pop_front()));
            else                 chk("m0_rdata", 32'(m0_rdata), 32'(exp_resp0.pop_front()));
          end
          if (!mf && prev_mfc[m]) begin
            chk("mfc_drop_after_req", 32'(last_req[m]), 32'd0);
            chk("gnt_release", 32'(gnt), 32'd0);
          end
          prev_mfc[m] = mf;
        end
        prev_strobe = strobe;
        prev_gnt = gnt;
      end
    end
  end

  task automatic drive(input int m, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (m == 1) begin m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d; end
    else        begin m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic do_access(input int m, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, output int lat);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d;
    @(negedge clk);
    if (m == 1) exp_req1.push_back(r); else exp_req0.push_back(r);
    drive(m, rd, wr, a, d);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if ((m == 1) ? m1_mfc : m0_mfc) break;
      if (lat >= 100) begin
        checks++; errors++;
        $display("FAIL mfc_wait m%0d: no mfc after %0d cycles, required mfc", m, lat);
        break;
      end
    end
    if (m == 1) begin m1_rd = 1'b0; m1_wr = 1'b0; end
    else        begin m0_rd = 1'b0; m0_wr = 1'b0; end
  endtask

  task automatic master_run(input int m, input int n);
    int k, lat;
    for (int i = 0; i < n; i++) begin
      k = int'($urandom_range(0, 2));
      do_access(m, k != 1, k != 0, 16'($urandom_range(0, 15)), 16'($urandom), lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rstIn = 1'b1;
    @(negedge clk);
    @(negedge clk); #1 rstIn = 1'b0;
  endtask

  initial begin : main
    int lat, n, seen;
    req_t r;
    rstIn = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mfc", 32'({m1_mfc, m0_mfc}), 32'd0);
    chk("rst_rdata0", 32'(m0_rdata), 32'd0);
    chk("rst_rdata1", 32'(m1_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    #1 rstIn = 1'b0;

    // Single CPU read, memory ready two cycles after the strobe.
    mem_model[16'h0000] = 16'b1000000110001111;
    force_w = 2;
    fork
      do_access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, lat);
      begin @(negedge clk); @(negedge clk); chk("rd_strobe_latency", 32'(mem_rd), 32'd1); end
    join
    chk("rd_mfc_latency", 32'(lat), 32'd4);
    chk("rd_data", 32'(m0_rdata), 32'h818F);
    @(negedge clk);
    chk("rd_gnt_after", 32'(gnt), 32'd0);
    chk("rd_mfc_after", 32'(m0_mfc), 32'd0);

    // Zero-wait write from master 1, then read it back through master 0.
    force_w = 0;
    do_access(1, 1'b0, 1'b1, 16'h01F4, 16'd500, lat);
    chk("wr_mfc_latency", 32'(lat), 32'd2);
    do_access(0, 1'b1, 1'b0, 16'h01F4, 16'h0000, lat);
    chk("wr_readback", 32'(m0_rdata), 32'd500);

    // Contention straight out of reset: strict alternation.
    do_reset();
    force_w = 1;
    grant_log.delete();
    fork
      begin repeat (2) do_access(0, 1'b1, 1'b0, 16'h0003, 16'h0, lat); end
      begin repeat (2) do_access(1, 1'b1, 1'b0, 16'h0004, 16'h0, lat); end
    join
    chk("cont_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("cont_g0", 32'(grant_log[0]), 32'd0);
      chk("cont_g1", 32'(grant_log[1]), 32'd1);
      chk("cont_g2", 32'(grant_log[2]), 32'd0);
      chk("cont_g3", 32'(grant_log[3]), 32'd1);
    end

    // Timeout on a read with memory never ready.
    force_w = TMO;
    do_access(0, 1'b1, 1'b0, 16'h0033, 16'h0, lat);
    chk("tmo_mfc_latency", 32'(lat), 32'(TMO + 1));
    chk("tmo_rdata", 32'(m0_rdata), 32'hFFFF);

    // Master 1 withdraws during ACC.
    force_w = 3;
    r.wr = 1'b0; r.addr = 16'h0077; r.wdata = 16'h0;
    @(negedge clk);
    exp_req1.push_back(r);
    drive(1, 1'b1, 1'b0, 16'h0077, 16'h0);
    n = 0;
    while (gnt !== 2'b10 && n < 20) begin @(negedge clk); n++; end
    chk("wd_grant", 32'(gnt), 32'd2);
    m1_rd = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (m1_mfc) seen++; end
    chk("wd_no_mfc", 32'(seen), 32'd0);
    chk("wd_idle", 32'(gnt), 32'd0);

    // Give m1 priority, then reset in the middle of an m1 access.
    force_w = 0;
    do_access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
    force_w = TMO;
    r.wr = 1'b0; r.addr = 16'h0020; r.wdata = 16'h0;
    @(negedge clk);
    exp_req1.push_back(r);
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    n = 0;
    while (gnt !== 2'b10 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rstIn = 1'b1;
    #1;
    chk("arst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_mfc", 32'({m1_mfc, m0_mfc}), 32'd0);
    m1_rd = 1'b0;
    @(negedge clk);
    #1 rstIn = 1'b0;
    force_w = 1;
    grant_log.delete();
    fork
      do_access(0, 1'b1, 1'b0, 16'h0005, 16'h0, lat);
      do_access(1, 1'b1, 1'b0, 16'h0006, 16'h0, lat);
    join
    chk("arst_first_grant", 32'((grant_log.size() > 0) ? grant_log[0] : 9), 32'd0);

    // Randomised traffic from both masters.
    force_w = -1;
    fork
      master_run(0, 25);
      master_run(1, 25);
    join

    repeat (5) @(negedge clk);
    chk("resp0_drained", 32'(exp_resp0.size()), 32'd0);
    chk("resp1_drained", 32'(exp_resp1.size()), 32'd0);
    chk("req0_drained", 32'(exp_req0.size()), 32'd0);
    chk("req1_drained", 32'(exp_req1.size()), 32'd0);
    chk("bus_err_total", 32'(bus_err_cycles), 32'(timeouts_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the single memory port behind the multicycle CPU.
- Master 0 is the CPU controller/datapath, using the rdM/wrM/mfc/Abus/Dbus handshake. Master 1 is a DMA-style requester.
- Grants the memory round-robin, runs one access at a time, and generates each master's mfc from the memory's ready signal.
- Bounds every access with a timeout counter so a stalled memory cannot hang the CPU.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TMO, 15, maximum cycles in ACC waiting for mem_rdy before forced completion (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rstIn  in  1  asynchronous, active-high reset.
- m0_rd  in  1  master 0 read request, level, held until m0_mfc is seen.
- m0_wr  in  1  master 0 write request, level.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rdata  out  DW  master 0 read data, valid while m0_mfc=1.
- m0_mfc  out  1  master 0 memory-function-complete.
- m1_rd, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_mfc  same as master 0, for master 1.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_rdy.
- mem_rdy  in  1  memory completion, sampled only in ACC.
- gnt  out  2  one-hot current grant (01 = m0, 10 = m1, 00 = none).
- bus_err  out  1  one-cycle pulse when an access times out.

Behaviour:
- All outputs are registered.
- Reset (async, rstIn=1):
  - state=IDLE, gnt=00, all strobes and mfc 0, rdata regs 0, mem_addr/mem_wdata 0, bus_err 0, prio=0 (m0 favoured), tmo counter 0.
  - Reset mid-access clears everything immediately. The aborted access is not retried.
- Request: reqX = mX_rd | mX_wr.
  - mX_rd & mX_wr together is a write (write wins).
- States:
  - IDLE: if no req, stay.
    - If only one req, grant it.
    - If both, grant master prio.
    - On grant: latch addr, wdata, op into mem_* regs; set gnt; assert mem_rd or mem_wr; go to ACC. Strobes are high in the cycle after the request edge (latency 1).
  - ACC: hold strobes, address and data stable; increment tmo counter.
    - On mem_rdy=1: capture mem_rdata into the granted mX_rdata (reads only; writes leave rdata unchanged); drop strobes; go to ACK.
    - If the counter reaches TMO without mem_rdy: drop strobes, load rdata with all ones (reads), pulse bus_err for 1 cycle, go to ACK.
  - ACK: mX_mfc=1 for the granted master while its req remains high.
    - When reqX=0: mfc=0, gnt=00, prio = other master, go to IDLE.
    - If reqX is already 0 on entry (master withdrew during ACC), mfc is never asserted. Go directly to IDLE with the same prio update.
- Latency:
  - Request sampled at edge N gives mem strobe at N+1.
  - mem_rdy sampled at edge K gives mfc and rdata at K+1.
  - Minimum request-to-mfc is 2 cycles with zero-wait memory (mem_rdy high on first ACC cycle).
- Dead cycle: at least 1 IDLE cycle separates consecutive grants, so strobes are never asserted back-to-back across masters.
- Stability: requests, address or data changes from any master during ACC/ACK are ignored (latched values are used). The non-granted master waits with mfc=0.
- Fairness: alternates under continuous contention. A lone requester may be granted repeatedly.

Test Plan:
- Single CPU read:
  - Stimulus: m0_rd=1, m0_addr=16'h0000; memory returns 16'b1000000110001111 with mem_rdy 2 cycles after mem_rd.
  - Response: mem_rd high at N+1; m0_mfc and m0_rdata=16'h818F at rdy+1; m0_mfc drops the cycle after m0_rd drops; gnt returns to 00.
- Write:
  - Stimulus: m1_wr=1, addr=16'h01F4, wdata=16'd500, zero-wait memory.
  - Response: mem_wr=1, mem_addr=16'h01F4, mem_wdata=500 for exactly 1 cycle; m1_mfc 2 cycles after request.
- Contention:
  - Stimulus: m0_rd and m1_rd asserted on the same edge after reset; each master drops its request on mfc, and both re-request immediately, for 4 accesses total.
  - Response: grant order m0, m1, m0, m1 with ≥1 IDLE cycle between grants.
- Timeout:
  - Stimulus: m0_rd with mem_rdy held 0.
  - Response: strobe drops after exactly TMO(15) ACC cycles; bus_err is a 1-cycle pulse; m0_mfc=1 with m0_rdata=16'hFFFF.
- Withdraw and reset:
  - Stimulus: m1 drops m1_rd during ACC, then mem_rdy arrives.
  - Response: m1_mfc never rises and state returns to IDLE.
  - Stimulus: then assert rstIn mid-ACC of a new access.
  - Response: strobes, gnt and mfc go to 0 asynchronously; the next grant goes to m0 first.
